r2sdf_stage: RTL
================

Name: r2sdf_stage

Overview:
- Radix-2 single-path delay-feedback (SDF) stage for the streaming 64-point FFT. Pairs samples x[n] and x[n+DEPTH] through an internal combinational butterfly.
- Emits sums directly. Stores differences in a delay line and emits them during the next half-frame.
- Input: one complex sample per valid cycle. Output: one reordered complex sample per valid cycle. Drops into the stage chain ahead of twiddle multiplication.

Parameters:
- WIDTH, 14: bit width of each real/imag component, in and out.
- DEPTH, 32: butterfly span and delay-line length. Power of two, ≥2. Frame length is 2*DEPTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_re/in_im carry a sample this cycle
- in_re  input  WIDTH  input real, two's complement
- in_im  input  WIDTH  input imag, two's complement
- out_valid  output  1  out_re/out_im valid (registered)
- out_sof  output  1  first output sample of a frame (registered; only with out_valid)
- out_re  output  WIDTH  output real
- out_im  output  WIDTH  output imag

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - All outputs are 0.
  - Sample counter cnt = 0 and flag have_diff = 0.
  - Delay-line contents are don't-care; they are never emitted before being written.
- Counter:
  - cnt is log2(2*DEPTH) bits and advances only on in_valid; it wraps 2*DEPTH-1 → 0.
  - Phase A: cnt < DEPTH. Phase B: cnt ≥ DEPTH.
- Delay line:
  - DEPTH entries, 2*WIDTH each, addressed by cnt[log2(DEPTH)-1:0].
  - Read-before-write at the same address in the same cycle. Written only on in_valid.
- Phase A, in_valid=1:
  - head = mem[addr], which holds the diff from the previous frame.
  - mem[addr] ← input.
  - Next cycle: out = head, out_valid = have_diff, out_sof = 0.
- Phase B, in_valid=1:
  - a = mem[addr] (x[n]), b = input (x[n+DEPTH]).
  - Sum s = a+b; difference d = a−b.
  - mem[addr] ← d. Next cycle: out = s, out_valid = 1, out_sof = (cnt == DEPTH).
  - On cnt = 2*DEPTH-1: have_diff ← 1.
- in_valid=0: nothing changes except out_valid ← 0 and out_sof ← 0. out_re/out_im hold their last value. Stalls of any length are allowed mid-frame.
- Latency and output order:
  - First out_valid appears 1 cycle after the (DEPTH+1)th valid input.
  - Per frame, output order is s[0..DEPTH-1], then d[0..DEPTH-1] interleaved 1:1 with the next frame's phase-A inputs.
  - Draining the final frame's diffs requires DEPTH further valid inputs; the content of those inputs is irrelevant.
- Arithmetic: without the optional feature, outputs are WIDTH-bit modular (wrap on overflow, no saturation).
- Reset mid-operation: stored diffs are discarded and have_diff clears. The next output is the sum produced at the next cnt = DEPTH.

Optional Feature:
- Macro: R2SDF_STAGE_SCALE_EN.
- Defined:
  - s and d are computed at WIDTH+1 bits, sign-extended.
  - Each is arithmetically shifted right by 1 (truncation toward −inf) before store/output. This gives per-stage 1/2 scaling with no overflow.
- Undefined: WIDTH-bit wrap arithmetic as above.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package fft_pkg:
  - FFT_N = 64.
  - Default WIDTH.
  - Complex sample typedef (re/im WIDTH).
  - Function clog2 for counter/address widths.
- Natural sub-module: bf8, used as the combinational butterfly instance (a, b → a+b, a−b). With R2SDF_STAGE_SCALE_EN, the stage instantiates it with WIDTH+1 on sign-extended operands.
- Delay line stays inline as a register array; it maps to distributed RAM.

Test Plan:
- Reset: hold rst for 3 cycles with in_valid=1 → out_valid=0, out_sof=0, out_re=out_im=0 throughout; cnt restarts at 0.
- Ramp, DEPTH=32, WIDTH=14: in_re=n (0..63), in_im=0, continuous.
  - Outputs after inputs 32..63: re = 32, 34, …, 94, im=0.
  - out_sof on the first of them only.
  - Then 32 more inputs of zeros → 32 outputs re = −32 (0x3FE0), im=0.
- Stall: same ramp with in_valid toggling 1,0,1,0 → identical output sequence. out_valid is low exactly in the cycles after in_valid=0, and out values hold.
- Overflow wrap: a=0x1FFF, b=0x0001 (re) → sum 0x2000, diff 0x1FFE.
- R2SDF_STAGE_SCALE_EN build:
  - Ramp test gives sums 16, 17, …, 47 and diffs −16.
  - Overflow case gives sum 0x1000 and diff 0x0FFF.
- Mid-frame reset: assert rst at cnt=40, then send a fresh ramp → first output appears after the 33rd new input, value 32. No stale diffs are emitted before the first sum.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the streaming 64-point FFT stage chain.
package fft_pkg;

  localparam int FFT_N     = 64;
  localparam int DEF_WIDTH = 14;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] re;
    logic [DEF_WIDTH-1:0] im;
  } cplx_t;

  // Ceiling log2, used to size counters and addresses.
  function automatic int clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return int'(r);
  endfunction

endpackage

// File: rtl/r2sdf_stage_bf8.sv
// Combinational radix-2 butterfly: s = a + b, d = a - b, modular at W bits.
module bf8 #(
  parameter int W = 14
) (
  input  logic [W-1:0] a_re,
  input  logic [W-1:0] a_im,
  input  logic [W-1:0] b_re,
  input  logic [W-1:0] b_im,
  output logic [W-1:0] s_re,
  output logic [W-1:0] s_im,
  output logic [W-1:0] d_re,
  output logic [W-1:0] d_im
);

  // Sum and difference of the complex pair.
  always_comb begin
    s_re = a_re + b_re;
    s_im = a_im + b_im;
    d_re = a_re - b_re;
    d_im = a_im - b_im;
  end

endmodule

// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback FFT stage.
// Optional macro R2SDF_STAGE_SCALE_EN: butterfly at WIDTH+1 bits with a 1/2
// arithmetic scale on both sum and difference (no overflow).
module r2sdf_stage
  import fft_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  output logic             out_sof,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
);

  localparam int CW = clog2(2 * DEPTH);
  localparam int AW = clog2(DEPTH);

  logic [CW-1:0]        cnt;
  logic                 have_diff;
  logic [2*WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]        addr;
  logic                 phase_b;
  logic [WIDTH-1:0]     head_re, head_im;
  logic [WIDTH-1:0]     sum_re, sum_im, dif_re, dif_im;

  assign addr    = cnt[AW-1:0];
  assign phase_b = cnt[CW-1];
  assign {head_re, head_im} = mem[addr];

`ifdef R2SDF_STAGE_SCALE_EN
  logic [WIDTH:0] bs_re, bs_im, bd_re, bd_im;

  bf8 #(.W(WIDTH + 1)) u_bf (
    .a_re ({head_re[WIDTH-1], head_re}),
    .a_im ({head_im[WIDTH-1], head_im}),
    .b_re ({in_re[WIDTH-1], in_re}),
    .b_im ({in_im[WIDTH-1], in_im}),
    .s_re (bs_re),
    .s_im (bs_im),
    .d_re (bd_re),
    .d_im (bd_im)
  );

  // Dropping bit 0 of the WIDTH+1 result is the arithmetic shift by one.
  assign sum_re = WIDTH'(bs_re >> 1);
  assign sum_im = WIDTH'(bs_im >> 1);
  assign dif_re = WIDTH'(bd_re >> 1);
  assign dif_im = WIDTH'(bd_im >> 1);
`else
  bf8 #(.W(WIDTH)) u_bf (
    .a_re (head_re),
    .a_im (head_im),
    .b_re (in_re),
    .b_im (in_im),
    .s_re (sum_re),
    .s_im (sum_im),
    .d_re (dif_re),
    .d_im (dif_im)
  );
`endif

  // Delay line: phase A stores the raw input, phase B stores the difference.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[addr] <= phase_b ? {dif_re, dif_im} : {in_re, in_im};
    end
  end

  // Sample counter, diff-available flag and registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      have_diff <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      if (in_valid) begin
        cnt <= cnt + 1'b1;
        if (!phase_b) begin
          // Head data only loaded when it is a real diff, so unwritten
          // delay-line words never reach the output registers.
          out_valid <= have_diff;
          if (have_diff) begin
            out_re <= head_re;
            out_im <= head_im;
          end
        end else begin
          out_valid <= 1'b1;
          out_sof   <= (cnt == CW'(DEPTH));
          out_re    <= sum_re;
          out_im    <= sum_im;
          if (cnt == CW'(2 * DEPTH - 1)) have_diff <= 1'b1;
        end
      end
    end
  end

endmodule
